// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// State encoding, port index and lock counter sizing.
package mem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef logic port_t;

    localparam int LOCK_MAX_DEF = 4;

    function automatic int lock_cnt_w(input int lock_max);
        return $clog2(lock_max + 1);
    endfunction

    localparam int LOCK_CNT_W = lock_cnt_w(LOCK_MAX_DEF);

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
// slave = arbiter view, master = core/memory view.
interface mem_arbiter_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
);
    logic              req0, req1;
    logic              we0, we1;
    logic              lock0, lock1;
    logic [AWIDTH-1:0] addr0, addr1;
    logic [DWIDTH-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DWIDTH-1:0] rdata0, rdata1;
    logic [AWIDTH-1:0] mem_raddr;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_raddr, mem_we, mem_waddr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_raddr, mem_we, mem_waddr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on contention prio_i wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_t      prio_i,
    output logic [1:0] gnt_o
);

    assign gnt_o[0] = req_i[0] & (~req_i[1] | ~prio_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] |  prio_i);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin with bounded lock,
// single grant per cycle, 1-cycle read return to the issuer.
module mem_arbiter #(
    parameter int AWIDTH   = 16,
    parameter int DWIDTH   = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    import mem_arb_pkg::*;

    localparam int CW = lock_cnt_w(LOCK_MAX);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(LOCK_MAX);

    arb_state_e        state_q, state_d;
    port_t             owner_q, owner_d;
    port_t             prio_q, prio_d;
    port_t             rd_owner_q, rd_owner_d;
    cnt_t              cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [AWIDTH-1:0] raddr_q, raddr_d;

    logic [1:0]        req;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic              hold;
    logic              any;
    port_t             pick_prio;
    port_t             g;
    logic              g_we;
    logic              g_lock;
    logic [AWIDTH-1:0] g_addr;
    logic [DWIDTH-1:0] g_wdata;
    cnt_t              cnt_inc;

    assign req       = {bus.req1, bus.req0};
    assign hold      = (state_q == LOCKED) && req[owner_q];
    // An idle owner gives up the lock; the other port then has priority.
    assign pick_prio = (state_q == LOCKED) ? ~owner_q : prio_q;

    rr_pick2 u_pick (
        .req_i  (req),
        .prio_i (pick_prio),
        .gnt_o  (pick)
    );

    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (hold) gnt = owner_q ? 2'b10 : 2'b01;
            else      gnt = pick;
        end
    end

    assign any     = |gnt;
    assign g       = gnt[1];
    assign g_we    = g ? bus.we1    : bus.we0;
    assign g_lock  = g ? bus.lock1  : bus.lock0;
    assign g_addr  = g ? bus.addr1  : bus.addr0;
    assign g_wdata = g ? bus.wdata1 : bus.wdata0;
    assign cnt_inc = cnt_q + cnt_t'(1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            hold: begin
                prio_d = ~owner_q;
                cnt_d  = cnt_inc;
                if (!g_lock || cnt_inc == CNT_MAX) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            end
            (any && !hold): begin
                prio_d = ~g;
                if (g_lock) begin
                    state_d = LOCKED;
                    owner_d = g;
                    cnt_d   = cnt_t'(1);
                end else begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            end
            (state_q == LOCKED && !hold && !any): begin
                state_d = ARB;
                prio_d  = ~owner_q;
                cnt_d   = '0;
            end
            default: ;
        endcase
    end

    assign rvalid_d   = any & ~g_we;
    assign rd_owner_d = rvalid_d ? g : rd_owner_q;
    assign raddr_d    = any ? g_addr : raddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rd_owner_q <= 1'b0;
            raddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            rd_owner_q <= rd_owner_d;
            raddr_q    <= raddr_d;
        end
    end

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.rvalid0   = rvalid_q & ~rd_owner_q;
    assign bus.rvalid1   = rvalid_q &  rd_owner_q;
    assign bus.rdata0    = bus.mem_rdata;
    assign bus.rdata1    = bus.mem_rdata;
    assign bus.mem_raddr = any ? g_addr : raddr_q;
    assign bus.mem_we    = any & g_we;
    assign bus.mem_waddr = g_addr;
    assign bus.mem_wdata = g_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model.
// Per-cycle vectors plus a hand sequence for reset during a read.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mem_arbiter_if #(.AWIDTH(16), .DWIDTH(16)) bus ();

    mem_arbiter #(
        .AWIDTH   (16),
        .DWIDTH   (16),
        .LOCK_MAX (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [0:255];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_waddr[7:0]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_raddr[7:0]];
    end

    typedef struct {
        logic        r0, r1, w0, w1, l0, l1;
        logic [15:0] a0, a1, d1;
        logic        g0, g1, mwe, rv0, rv1;
        logic [15:0] rd;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(
        input logic r0, r1, w0, w1, l0, l1,
        input logic [15:0] a0, a1, d1,
        input logic g0, g1, mwe, rv0, rv1,
        input logic [15:0] rd
    );
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.w0 = w0; t.w1 = w1;
        t.l0 = l0; t.l1 = l1;
        t.a0 = a0; t.a1 = a1; t.d1 = d1;
        t.g0 = g0; t.g1 = g1; t.mwe = mwe;
        t.rv0 = rv0; t.rv1 = rv1; t.rd = rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_row(input logic rv0, input logic rv1,
                            input logic [15:0] rd);
        v.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0,
                       0, 0, 0, rv0, rv1, rd));
    endtask

    task automatic both_rd(input logic l1, input logic g0,
                           input logic g1, input logic rv0,
                           input logic rv1, input logic [15:0] rd);
        v.push_back(mk(1, 1, 0, 0, 0, l1, 16'h0010, 16'h0020, 16'h0,
                       g0, g1, 0, rv0, rv1, rd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
        bus.mem_rdata = 16'h0;
        rst_n      = 1'b0;
        bus.req0   = 1'b1;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.lock0  = 1'b0;
        bus.lock1  = 1'b0;
        bus.addr0  = 16'h0010;
        bus.addr1  = 16'h0;
        bus.wdata0 = 16'h1234;
        bus.wdata1 = 16'h0;

        // Reset held with a request pending, then reset during a read.
        repeat (2) @(negedge clk);
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("pre_rst_gnt0", 32'(bus.gnt0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt0", 32'(bus.gnt0), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        bus.req0 = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("post_rst_rvalid1", 32'(bus.rvalid1), 32'd0);
        chk("post_rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("post_rst_gnt1", 32'(bus.gnt1), 32'd0);

        // Contention: alternating grants starting with port 0.
        both_rd(0, 1, 0, 0, 0, 16'h0);
        both_rd(0, 0, 1, 1, 0, 16'hA510);
        both_rd(0, 1, 0, 0, 1, 16'hA520);
        both_rd(0, 0, 1, 1, 0, 16'hA510);
        idle_row(0, 1, 16'hA520);
        idle_row(0, 0, 16'h0);
        // Write on port 1 then read-after-write on port 0.
        v.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0, 16'h0042, 16'hBEEF,
                       0, 1, 1, 0, 0, 16'h0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0042, 16'h0, 16'h0,
                       1, 0, 0, 0, 0, 16'h0));
        idle_row(1, 0, 16'hBEEF);
        // Port 1 lock: four grants, then port 0.
        both_rd(1, 0, 1, 0, 0, 16'h0);
        both_rd(1, 0, 1, 0, 1, 16'hA520);
        both_rd(1, 0, 1, 0, 1, 16'hA520);
        both_rd(1, 0, 1, 0, 1, 16'hA520);
        both_rd(1, 1, 0, 0, 1, 16'hA520);
        idle_row(1, 0, 16'hA510);
        // Port 0 lock released early; port 1 served same cycle.
        v.push_back(mk(1, 0, 0, 0, 1, 0, 16'h0010, 16'h0, 16'h0,
                       1, 0, 0, 0, 0, 16'h0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0, 16'h0020, 16'h0,
                       0, 1, 0, 1, 0, 16'hA510));
        idle_row(0, 1, 16'hA520);
        // Ten idle cycles must leave priority with port 0.
        for (int k = 0; k < 10; k++) idle_row(0, 0, 16'h0);
        both_rd(0, 1, 0, 0, 0, 16'h0);
        idle_row(1, 0, 16'hA510);

        for (int i = 0; i < v.size(); i++) begin
            @(posedge clk);
            #1;
            bus.req0  = v[i].r0;
            bus.req1  = v[i].r1;
            bus.we0   = v[i].w0;
            bus.we1   = v[i].w1;
            bus.lock0 = v[i].l0;
            bus.lock1 = v[i].l1;
            bus.addr0 = v[i].a0;
            bus.addr1 = v[i].a1;
            bus.wdata1 = v[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), 32'(bus.gnt0), 32'(v[i].g0));
            chk($sformatf("v%0d_gnt1", i), 32'(bus.gnt1), 32'(v[i].g1));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we),
                32'(v[i].mwe));
            chk($sformatf("v%0d_rvalid0", i), 32'(bus.rvalid0),
                32'(v[i].rv0));
            chk($sformatf("v%0d_rvalid1", i), 32'(bus.rvalid1),
                32'(v[i].rv1));
            if (v[i].rv0)
                chk($sformatf("v%0d_rdata0", i), 32'(bus.rdata0),
                    32'(v[i].rd));
            if (v[i].rv1)
                chk($sformatf("v%0d_rdata1", i), 32'(bus.rdata1),
                    32'(v[i].rd));
            if (v[i].g0 || v[i].g1)
                chk($sformatf("v%0d_mem_raddr", i), 32'(bus.mem_raddr),
                    32'(v[i].g1 ? v[i].a1 : v[i].a0));
            if (v[i].mwe) begin
                chk($sformatf("v%0d_mem_waddr", i), 32'(bus.mem_waddr),
                    32'(v[i].a1));
                chk($sformatf("v%0d_mem_wdata", i), 32'(bus.mem_wdata),
                    32'(v[i].d1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
